// File: rtl/mips_exec_mem_stage.sv
// Execute/memory slice of the single-cycle MIPS datapath: ALU, PC adders, 256-word data memory, write-back mux.
// Optional DMEM_RESET_CLEAR_EN: asynchronous reset also clears every data-memory word to zero.
module mips_exec_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [15:0] imm16,
  input  logic        alu_src,
  input  logic [3:0]  alu_op,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_to_reg,
  input  logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        lt,
  output logic        gt,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_data,
  output logic [31:0] pc_next,
  output logic [31:0] branch_target
);

  logic [31:0] immExt;
  logic [31:0] operandB;
  logic [7:0]  memAddr;
  logic [31:0] memArray [0:255];

  always_comb begin
    immExt   = {{16{imm16[15]}}, imm16};
    operandB = alu_src ? immExt : read_data2;
  end

  // Flags compare the operands directly so they are meaningful for every alu_op.
  always_comb begin
    lt = $signed(read_data1) < $signed(operandB);
    gt = $signed(read_data1) > $signed(operandB);
    case (alu_op)
      4'b0000: alu_result = read_data1 & operandB;
      4'b0001: alu_result = read_data1 | operandB;
      4'b0010: alu_result = read_data1 + operandB;
      4'b0011: alu_result = read_data1 ^ operandB;
      4'b0110: alu_result = read_data1 - operandB;
      4'b0111: alu_result = {31'b0, lt};
      4'b1100: alu_result = ~(read_data1 | operandB);
      4'b1000: alu_result = operandB << read_data1[4:0];
      4'b1001: alu_result = operandB >> read_data1[4:0];
      default: alu_result = 32'd0;
    endcase
    zero = (alu_result == 32'd0);
  end

  always_comb begin
    pc_next       = pc + 32'd1;
    branch_target = pc_next + immExt;
  end

  assign memAddr = alu_result[7:0];

`ifdef DMEM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) memArray[i] <= 32'd0;
    end else if (mem_write) begin
      memArray[memAddr] <= read_data2;
    end
  end
`else
  // Memory is left untouched by reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (rst_n && mem_write) memArray[memAddr] <= read_data2;
  end
`endif

  always_comb begin
    mem_rdata = mem_read ? memArray[memAddr] : 32'd0;
    if (mem_to_reg[1])      wb_data = mem_rdata;
    else if (mem_to_reg[0]) wb_data = {31'b0, lt};
    else                    wb_data = alu_result;
  end

endmodule

// File: tb/tb_mips_exec_mem_stage.sv
// Self-checking bench for mips_exec_mem_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_mips_exec_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] read_data1, read_data2, pc;
  logic [15:0] imm16;
  logic        alu_src, mem_read, mem_write;
  logic [3:0]  alu_op;
  logic [1:0]  mem_to_reg;
  logic [31:0] alu_result, mem_rdata, wb_data, pc_next, branch_target;
  logic        zero, lt, gt;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 0;

  logic [31:0] modelMem   [0:255];
  bit          modelKnown [0:255];

`ifdef DMEM_RESET_CLEAR_EN
  localparam logic [31:0] RST_WORD = 32'd0;
`else
  localparam logic [31:0] RST_WORD = 32'h12345678;
`endif

  mips_exec_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .read_data1(read_data1), .read_data2(read_data2),
    .imm16(imm16), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .pc(pc), .alu_result(alu_result),
    .zero(zero), .lt(lt), .gt(gt), .mem_rdata(mem_rdata), .wb_data(wb_data),
    .pc_next(pc_next), .branch_target(branch_target)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] modelOpB();
    return alu_src ? 32'($signed(imm16)) : read_data2;
  endfunction

  function automatic logic [31:0] modelAlu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                               input logic src, input logic [3:0] op, input logic mr,
                               input logic mw, input logic [1:0] m2r, input logic [31:0] pcv);
    @(posedge clk);
    #1;
    read_data1 = a; read_data2 = b; imm16 = imm; alu_src = src; alu_op = op;
    mem_read = mr; mem_write = mw; mem_to_reg = m2r; pc = pcv;
  endtask

  // Reference memory: written at the clock edge when out of reset.
  always @(posedge clk) begin
    logic [31:0] r;
    r = modelAlu(read_data1, modelOpB(), alu_op);
    if (rst_n === 1'b1 && mem_write === 1'b1) begin
      modelMem[r[7:0]]   = read_data2;
      modelKnown[r[7:0]] = 1;
    end
  end

`ifdef DMEM_RESET_CLEAR_EN
  always @(negedge rst_n) begin
    for (int i = 0; i < 256; i++) begin
      modelMem[i] = 32'd0;
      modelKnown[i] = 1;
    end
  end
`endif

  // Compare every output against the model once per cycle, mid-way between edges.
  always @(negedge clk) begin
    logic [31:0] b, r, expRd;
    logic        expLt, rdValid;
    if (checkEn) begin
      b     = modelOpB();
      r     = modelAlu(read_data1, b, alu_op);
      expLt = $signed(read_data1) < $signed(b);
      rdValid = !mem_read || modelKnown[r[7:0]];
      expRd = mem_read ? modelMem[r[7:0]] : 32'd0;
      checkOutput("alu_result", alu_result, r);
      checkOutput("zero", {31'b0, zero}, {31'b0, r == 32'd0});
      checkOutput("lt", {31'b0, lt}, {31'b0, expLt});
      checkOutput("gt", {31'b0, gt}, {31'b0, $signed(read_data1) > $signed(b)});
      checkOutput("pc_next", pc_next, pc + 32'd1);
      checkOutput("branch_target", branch_target, pc + 32'd1 + 32'($signed(imm16)));
      if (rdValid) checkOutput("mem_rdata", mem_rdata, expRd);
      if (!mem_to_reg[1])      checkOutput("wb_data", wb_data, mem_to_reg[0] ? {31'b0, expLt} : r);
      else if (rdValid)        checkOutput("wb_data_mem", wb_data, expRd);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      modelMem[i] = 32'd0;
      modelKnown[i] = 0;
    end
    read_data1 = 0; read_data2 = 0; imm16 = 0; alu_src = 0; alu_op = 0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; pc = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #3;
    checkOutput("reset alu_result", alu_result, 32'd0);
    checkOutput("reset zero", {31'b0, zero}, 32'd1);
    checkOutput("reset pc_next", pc_next, 32'd1);
    @(posedge clk); #1 rst_n = 1;
    checkEn = 1;

    applyStimulus(5, 3, 0, 0, 4'b0010, 0, 0, 2'b00, 0); #2;
    checkOutput("add 5+3", alu_result, 32'd8);
    checkOutput("add zero", {31'b0, zero}, 32'd0);
    checkOutput("add gt", {31'b0, gt}, 32'd1);
    applyStimulus(5, 3, 0, 0, 4'b0110, 0, 0, 2'b00, 0); #2;
    checkOutput("sub 5-3", alu_result, 32'd2);
    applyStimulus(5, 3, 0, 0, 4'b0111, 0, 0, 2'b00, 0); #2;
    checkOutput("slt 5<3", alu_result, 32'd0);

    applyStimulus(32'hFFFFFFFF, 1, 0, 0, 4'b0110, 0, 0, 2'b01, 0); #2;
    checkOutput("sub -1-1", alu_result, 32'hFFFFFFFE);
    checkOutput("signed lt", {31'b0, lt}, 32'd1);
    checkOutput("signed gt", {31'b0, gt}, 32'd0);
    checkOutput("wb lt select", wb_data, 32'd1);

    applyStimulus(10, 0, 16'hFFFC, 1, 4'b0010, 0, 0, 2'b00, 100); #2;
    checkOutput("imm add", alu_result, 32'd6);
    checkOutput("imm pc_next", pc_next, 32'd101);
    checkOutput("imm branch_target", branch_target, 32'd97);

    applyStimulus(4, 1, 0, 0, 4'b1000, 0, 0, 2'b00, 0); #2;
    checkOutput("sll", alu_result, 32'd16);
    applyStimulus(31, 32'h80000000, 0, 0, 4'b1001, 0, 0, 2'b00, 0); #2;
    checkOutput("srl", alu_result, 32'd1);
    applyStimulus(5, 3, 0, 0, 4'b0101, 0, 0, 2'b00, 0); #2;
    checkOutput("undefined op", alu_result, 32'd0);

    applyStimulus(7, 32'hDEADBEEF, 0, 1, 4'b0010, 0, 1, 2'b00, 0);
    applyStimulus(7, 0, 0, 1, 4'b0010, 1, 0, 2'b10, 0); #2;
    checkOutput("mem read", mem_rdata, 32'hDEADBEEF);
    checkOutput("wb mem select", wb_data, 32'hDEADBEEF);
    applyStimulus(7, 0, 0, 1, 4'b0010, 0, 0, 2'b10, 0); #2;
    checkOutput("mem_read low", mem_rdata, 32'd0);

    applyStimulus(32'h107, 32'h12345678, 0, 1, 4'b0010, 1, 1, 2'b00, 32'hFFFFFFFF); #2;
    checkOutput("read before write", mem_rdata, 32'hDEADBEEF);
    checkOutput("pc wrap", pc_next, 32'd0);
    applyStimulus(7, 0, 0, 1, 4'b0010, 1, 0, 2'b10, 0); #2;
    checkOutput("addr wrap write", mem_rdata, 32'h12345678);

    #2 rst_n = 0;
    #1 checkOutput("read under reset", mem_rdata, RST_WORD);
    applyStimulus(7, 32'hCAFEF00D, 0, 1, 4'b0010, 1, 1, 2'b10, 0);
    applyStimulus(7, 0, 0, 1, 4'b0010, 1, 0, 2'b10, 0);
    rst_n = 1; #2;
    checkOutput("write suppressed in reset", mem_rdata, RST_WORD);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [15:0] imm;
      if ($urandom_range(0, 1) == 1) begin
        a   = ($urandom() << 8) | 32'($urandom_range(0, 15));
        imm = 16'($urandom_range(0, 15));
        applyStimulus(a, $urandom(), imm, 1, 4'b0010, 1'($urandom()), 1'($urandom()),
                      2'($urandom()), $urandom());
      end else begin
        applyStimulus($urandom(), $urandom(), 16'($urandom()), 1'($urandom()), 4'($urandom()),
                      1'($urandom()), 1'($urandom()), 2'($urandom()), $urandom());
      end
    end

    @(posedge clk); #6;
    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
